lsu_dmem_ctrl: RTL and testbench
================================

// Module: lsu_dmem_ctrl
// PURPOSE
//  Load/store unit between core execute stage and the word-wide DMEM (1024x32, word write only, 1-cycle registered read).
//  Converts byte/half/word loads and stores into word accesses: extracts and sign/zero-extends load lanes, and runs a
//  read-modify-write sequence for sub-word stores. Flags misaligned, reserved-size and out-of-range accesses.
// PARAMETERS
//  DMEM_AW  12  byte-address width backed by DMEM; addr >= 2**DMEM_AW is out of range
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  req_valid     in   1   core request valid
//  req_ready     out  1   high only in IDLE; request accepted on req_valid && req_ready
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1   loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid    out  1   one-cycle pulse, completion of accepted request; no backpressure, core must take it
//  resp_err      out  1   valid with resp_valid: misaligned / reserved size / out of range
//  resp_rdata    out  32  load result, valid with resp_valid; 0 for stores and errors
//  dmem_addr     out  32  word address to DMEM, always {addr[31:2],2'b00}
//  dmem_wdata    out  32  full word to DMEM
//  dmem_we       out  1   DMEM write enable, high only in WR, decoded from state register
//  dmem_rdata    in   32  DMEM registered read data, valid the cycle after a non-write DMEM cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0,
//   dmem_addr=0, dmem_wdata=0, latched request regs=0. Reset mid-operation aborts; a pending RMW write is dropped.
//  Accept in IDLE latches we/size/unsigned/addr/wdata. Error check at accept: size==11; half && addr[0];
//   word && addr[1:0]!=0; addr[31:DMEM_AW]!=0 -> RESP with err=1, no DMEM cycle of any kind.
//  FSM: IDLE, RD, RD_WAIT, WR, RESP. Cycle counts below from first cycle after accept edge (C1):
//   load:          IDLE->RD->RD_WAIT->RESP       resp_valid in C3
//   word store:    IDLE->WR->RESP                resp_valid in C2
//   sub-word store IDLE->RD->RD_WAIT->WR->RESP   resp_valid in C4
//   error:         IDLE->RESP                    resp_valid in C1
//  RD: dmem_we=0, dmem_addr driven; DMEM captures. RD_WAIT: dmem_rdata valid; load -> extract into resp_rdata;
//   sub-word store -> merge into latched wdata (only selected lanes replaced, others from dmem_rdata).
//  WR: dmem_we=1 exactly one cycle, dmem_wdata = merged or full word. RESP: resp_valid=1 one cycle, then IDLE.
//  dmem_addr/dmem_wdata hold last values outside active states; dmem_we=0 in every state except WR.
//  Lane rules: byte lane k=addr[1:0], bits [8k+7:8k]; half lane addr[1], bits [16h+15:16h].
//   Load byte: {24{~uns & b[7]}, b}; half: {16{~uns & h[15]}, h}; word: passthrough.
//   Store merge: byte lane k <- wdata[7:0]; half lane h <- wdata[15:0]; word needs no read.
//  req_ready=0 in all non-IDLE states incl. RESP: one request in flight, next accept earliest in cycle after RESP.
//  resp_err and resp_rdata are registered, cleared to 0 on every accept, hold value until next accept.
// STRUCTURE
//  lsu_pkg: size encodings (SZ_B/SZ_H/SZ_W/SZ_RSV), state enum (IDLE/RD/RD_WAIT/WR/RESP).
//  Sub-module lsu_lane_align (combinational): load extract + sign/zero-extend, store merge; instanced once.
//  Top: FSM, request latch, error decode, response registers.
// TESTING (bench pairs this block with a DMEM model: word write, registered read)
//  1 sw addr 0x10 data 0xDEADBEEF -> dmem_we=1 in C1 with dmem_addr 0x10, resp_valid C2 err=0; lw 0x10 -> 0xDEADBEEF in C3.
//  2 mem[0x10]=0xDEADBEEF; lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
//  3 sb 0x11 data 0x55 on 0xDEADBEEF -> single we in C3, mem=0xDEAD55EF, resp C4; sh 0x12 0x1234 -> 0x123455EF.
//  4 lw 0x12, lh 0x11, size=11, lw 0x1000 (DMEM_AW=12) -> resp_valid C1, err=1, rdata=0, dmem_we never asserted.
//  5 back-to-back: req_valid held high for sb then lw -> req_ready low C1..C4, second accept in C5 IDLE, lw returns merged word.
//  6 rst_n low during WR of an sb (and during RD) -> dmem_we drops immediately, memory unchanged, outputs at reset values, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared encodings for the load/store unit: access size codes and the
// controller state enumeration. No ports.
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Access size as presented on req_size.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } lsu_size_e;

  // Controller states. RD drives the read, RD_WAIT consumes the registered data.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_dmem_ctrl_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align (combinational)
// Load path: selects the byte/half lane from a DMEM word and sign/zero-extends.
// Store path: merges right-aligned store data into the read word's lanes.
// Ports:
//   size_i   access size (lsu_size_e encoding)
//   uns_i    1 = zero-extend loads
//   off_i    byte offset within the word (addr[1:0])
//   rdata_i  word read from DMEM
//   wdata_i  right-aligned store data
//   load_o   extended load result
//   merge_o  word to write back for a store
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and load extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    load_o = 32'h0000_0000;
    case (off_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (size_i)
      SZ_B:    load_o = {{24{~uns_i & byte_s[7]}}, byte_s};
      SZ_H:    load_o = {{16{~uns_i & half_s[15]}}, half_s};
      SZ_W:    load_o = rdata_i;
      default: load_o = 32'h0000_0000;
    endcase
  end

  // Store merge: only the addressed lane takes new data, the rest keep DMEM contents.
  always_comb begin
    merge_o = rdata_i;
    case (size_i)
      SZ_B: begin
        case (off_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          2'd3:    merge_o[31:24] = wdata_i[7:0];
          default: merge_o = rdata_i;
        endcase
      end
      SZ_H: begin
        if (off_i[1]) begin
          merge_o[31:16] = wdata_i[15:0];
        end else begin
          merge_o[15:0] = wdata_i[15:0];
        end
      end
      SZ_W:    merge_o = wdata_i;
      default: merge_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_dmem_ctrl
// Load/store unit between the execute stage and a word-wide DMEM with 1-cycle
// registered read. Sub-word stores run read-modify-write; misaligned, reserved
// size and out-of-range requests complete immediately with an error.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we/req_size/req_unsigned    store flag, size code, load zero-extend
//   req_addr/req_wdata              byte address, right-aligned store data
//   resp_valid/resp_err/resp_rdata  one-cycle completion pulse with result
//   dmem_addr/dmem_wdata/dmem_we    DMEM word address, write data, write enable
//   dmem_rdata                      DMEM registered read data
// -----------------------------------------------------------------------------
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;

  logic        accept_s;
  logic        size_err_s;
  logic        oor_s;
  logic        err_s;
  logic        word_st_s;
  logic [31:0] load_s;
  logic [31:0] merge_s;

  assign accept_s  = req_valid && (state_q == IDLE);
  assign oor_s     = |req_addr[31:DMEM_AW];
  assign err_s     = size_err_s | oor_s;
  assign word_st_s = req_we && (req_size == SZ_W);

  // Size/alignment legality of the incoming request.
  always_comb begin
    size_err_s = 1'b0;
    case (req_size)
      SZ_B:    size_err_s = 1'b0;
      SZ_H:    size_err_s = req_addr[0];
      SZ_W:    size_err_s = (req_addr[1:0] != 2'b00);
      default: size_err_s = 1'b1;
    endcase
  end

  lsu_lane_align u_align (
    .size_i  (size_q),
    .uns_i   (uns_q),
    .off_i   (off_q),
    .rdata_i (dmem_rdata),
    .wdata_i (wdata_q),
    .load_o  (load_s),
    .merge_o (merge_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; full-word stores skip the read, errors skip DMEM entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (err_s) begin
          state_d = RESP;
        end else if (word_st_s) begin
          state_d = WR;
        end else begin
          state_d = RD;
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        if (we_q) begin
          state_d = WR;
        end else begin
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state register.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_we    = 1'b0;
    case (state_q)
      IDLE:    req_ready  = 1'b1;
      WR:      dmem_we    = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request latch, response registers and DMEM address/data registers.
  // dmem_addr is loaded at accept so the DMEM cycle can start in C1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      dmem_addr_q  <= 32'h0000_0000;
      dmem_wdata_q <= 32'h0000_0000;
    end else if (accept_s) begin
      we_q         <= req_we;
      size_q       <= req_size;
      uns_q        <= req_unsigned;
      off_q        <= req_addr[1:0];
      wdata_q      <= req_wdata;
      resp_err_q   <= err_s;
      resp_rdata_q <= 32'h0000_0000;
      if (!err_s) begin
        dmem_addr_q <= {req_addr[31:2], 2'b00};
        if (word_st_s) begin
          dmem_wdata_q <= req_wdata;
        end
      end
    end else if (state_q == RD_WAIT) begin
      if (we_q) begin
        dmem_wdata_q <= merge_s;
      end else begin
        resp_rdata_q <= load_s;
      end
    end
  end

  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_dmem_ctrl
// Pairs lsu_dmem_ctrl with a word-write / registered-read DMEM model and checks
// every response against a byte-lane reference model of memory.
// -----------------------------------------------------------------------------
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.DMEM_AW(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata)
  );

  // DMEM: word write, registered read on every non-write cycle.
  always @(posedge clk) begin
    if (dmem_we) dmem[dmem_addr[11:2]] <= dmem_wdata;
    else         dmem_rdata <= dmem[dmem_addr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || (a >= 32'h1000);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    w = ref_mem[a[11:2]];
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * (a % 4))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    sh = 8 * (a % 4);
    if (sz == 2'd0)      m = 32'hFF << sh;
    else if (sz == 2'd1) m = 32'hFFFF << sh;
    else                 m = 32'hFFFF_FFFF;
    ref_mem[a[11:2]] = (ref_mem[a[11:2]] & ~m) | ((wd << sh) & m);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 32'd1);
    chk({tag, "_rvalid"}, resp_valid, 32'd0);
    chk({tag, "_rerr"}, resp_err, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_we"}, dmem_we, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
  endtask

  // One complete request: latency, error, data, DMEM write count/timing/address.
  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
    bit          e;
    int          lat;
    int          exp_we;
    logic [31:0] d;
    int          c;
    int          wecnt;
    bit          got;
    e      = exp_err(sz, a);
    lat    = e ? 1 : (!we ? 3 : (sz == 2'd2 ? 2 : 4));
    exp_we = (e || !we) ? 0 : 1;
    d      = (e || we) ? 32'd0 : ref_load(sz, uns, a);
    @(negedge clk);
    chk("ready_idle", req_ready, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    c = 0; wecnt = 0; got = 1'b0;
    while (!got && c < 10) begin
      @(negedge clk);
      c++;
      chk("busy", req_ready, 32'd0);
      if (!e && c == 1) chk("c1_addr", dmem_addr, {a[31:2], 2'b00});
      if (dmem_we) begin
        wecnt++;
        chk("wr_addr", dmem_addr, {a[31:2], 2'b00});
        chk("wr_cycle", c, lat - 1);
      end
      if (resp_valid) begin
        got = 1'b1;
        chk("latency", c, lat);
        chk("resp_err", resp_err, e);
        chk("resp_rdata", resp_rdata, d);
      end
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    chk("we_count", wecnt, exp_we);
    @(negedge clk);
    chk("pulse_end", resp_valid, 32'd0);
    chk("err_hold", resp_err, e);
    chk("rdata_hold", resp_rdata, d);
    if (we && !e) begin
      ref_store(sz, a, wd);
      chk("mem_word", dmem[a[11:2]], ref_mem[a[11:2]]);
    end
  endtask

  initial begin
    int          c;
    bit          got;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents for the region used by later loads.
    for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

    // Word store/load, sign/zero-extended loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    chk("lb_value", ref_load(2'd0, 1'b0, 32'h13), 32'hFFFFFFDE);

    // Sub-word read-modify-write.
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("rmw_word", dmem[4], 32'h123455EF);

    // Error cases.
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h8000_0004, 32'h77);

    // Back-to-back: valid held high across an sb then an lw.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000C3;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20;
    ref_store(2'd0, 32'h21, 32'h000000C3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("b2b_busy", req_ready, 32'd0);
    end
    chk("b2b_resp1", resp_valid, 32'd1);
    @(negedge clk);
    chk("b2b_ready_c5", req_ready, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c = 0; got = 1'b0;
    while (!got && c < 10) begin
      @(negedge clk);
      c++;
      if (resp_valid) begin
        got = 1'b1;
        chk("b2b_lat", c, 32'd3);
        chk("b2b_rdata", resp_rdata, ref_mem[8]);
      end
    end
    if (!got) chk("b2b_timeout", 32'd0, 32'd1);

    // Reset during WR of a byte store: write must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h22; req_wdata = 32'h000000A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c = 0;
    while (!dmem_we && c < 6) begin
      @(negedge clk);
      c++;
    end
    chk("rst_wr_cycle", c, 32'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_wr");
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mem", dmem[8], ref_mem[8]);

    // Reset during RD of a load.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_rd");
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Randomized mix.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 15);
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 19);
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 63);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
